// File: rtl/fwrisc_wb_ram_target_if.sv
// Wishbone classic bus bundle between a master and the RAM target.
// The RAM target connects to it through the slave modport.
interface fwrisc_wb_ram_target_if;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic        ack;
    logic        err;

    modport master (output adr, dat_w, cyc, stb, we, sel, input dat_r, ack, err);
    modport slave  (input adr, dat_w, cyc, stb, we, sel, output dat_r, ack, err);
endinterface

// File: rtl/fwrisc_wb_ram_target.sv
// Wishbone RAM target with byte lanes and WAIT_STATES idle cycles before each response.
// Define FWRISC_WB_RAM_ERR_EN to terminate out-of-range or misaligned accesses with err.
module fwrisc_wb_ram_target #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1,
  parameter     INIT_FILE   = ""
) (
  input  logic                      clock,
  input  logic                      reset,
  fwrisc_wb_ram_target_if.slave     t
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [31:0]           mem [0:(1 << DEPTH_LOG2) - 1];

  state_t                state;
  logic [3:0]            wait_cnt;
  logic                  req;
  logic                  bad_req;
  logic                  enter_resp;
  logic                  do_write;

  logic [DEPTH_LOG2-1:0] idx_p0;
  logic [31:0]           dat_w_p0;
  logic                  we_p0;
  logic [3:0]            sel_p0;
  logic                  bad_p0;

  logic [DEPTH_LOG2-1:0] x_idx;
  logic [31:0]           x_dat;
  logic                  x_we;
  logic [3:0]            x_sel;
  logic                  x_bad;

  assign req = t.cyc && t.stb;

`ifdef FWRISC_WB_RAM_ERR_EN
  assign bad_req = (|t.adr[31:DEPTH_LOG2+2]) || (|t.adr[1:0]);
`else
  logic unused_adr;
  assign unused_adr = ^{t.adr[31:DEPTH_LOG2+2], t.adr[1:0]};
  assign bad_req    = 1'b0;
`endif

  // With zero wait states the RAM is accessed on the accepting edge, so the
  // live bus inputs stand in for the not-yet-latched request.
  always_comb begin
    x_idx = idx_p0;
    x_dat = dat_w_p0;
    x_we  = we_p0;
    x_sel = sel_p0;
    x_bad = bad_p0;
    if (state == IDLE) begin
      x_idx = t.adr[DEPTH_LOG2+1:2];
      x_dat = t.dat_w;
      x_we  = t.we;
      x_sel = t.sel;
      x_bad = bad_req;
    end
  end

  assign enter_resp = reset && req &&
                      (((state == IDLE) && (WAIT_STATES == 0)) ||
                       ((state == WAIT) && (wait_cnt == WAIT_LAST)));
  assign do_write   = enter_resp && x_we && !x_bad;

  // Request capture: data path, no reset needed
  always_ff @(posedge clock) begin
    if (state == IDLE && req) begin
      idx_p0   <= t.adr[DEPTH_LOG2+1:2];
      dat_w_p0 <= t.dat_w;
      we_p0    <= t.we;
      sel_p0   <= t.sel;
      bad_p0   <= bad_req;
    end
  end

  // RAM array: contents survive reset
  always_ff @(posedge clock) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (x_sel[b]) mem[x_idx][8*b +: 8] <= x_dat[8*b +: 8];
      end
    end
  end

  // Control FSM with registered ack/err and read data
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      t.ack    <= 1'b0;
      t.dat_r  <= 32'h0;
    end else begin
      t.ack <= 1'b0;
      if (enter_resp && !x_we && !x_bad) t.dat_r <= mem[x_idx];
      case (state)
        IDLE: begin
          wait_cnt <= 4'd0;
          if (req) state <= (WAIT_STATES == 0) ? RESP : WAIT;
        end
        WAIT: begin
          if (!req) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= RESP;
            wait_cnt <= 4'd0;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          t.ack <= !bad_p0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FWRISC_WB_RAM_ERR_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) t.err <= 1'b0;
    else        t.err <= (state == RESP) && bad_p0;
  end
`else
  assign t.err = 1'b0;
`endif

endmodule
